prio_encoder_rr: RTL and testbench

- Parametrised N-to-log2(N) priority encoder with a registered output stage.
- Selectable fixed-priority or round-robin mode.
- Valid/ready output handshake with back-pressure hold.
- Sits between a request vector (interrupt lines, FIFO-nonempty flags) and a downstream consumer that accepts one winning index per handshake.

---
 rtl/prio_encoder_rr_pkg.sv | 32 +++
 rtl/prio_encoder_rr_if.sv | 28 ++
 rtl/prio_encoder_rr_find.sv | 39 +++
 rtl/prio_encoder_rr.sv | 86 ++++++++
 tb/tb_prio_encoder_rr.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/prio_encoder_rr_pkg.sv
// Shared constants and bit-vector helpers for the round-robin priority encoder.
// Vectors are padded to 64 bits so the helpers serve any legal request width.
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic logic [5:0] highest_set(input logic [63:0] v);
    logic [5:0] h;
    h = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) h = i[5:0];
    end
    return h;
  endfunction

  // Rotate the low n bits of v upward by amt (0 <= amt < n); bits at n and above read as 0.
  function automatic logic [63:0] rot_up(input logic [63:0] v, input int amt, input int n);
    logic [63:0] r;
    int          src;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < n) begin
        src  = (i >= amt) ? i - amt : i + n - amt;
        r[i] = v[src[5:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/result bundle between the request source, the encoder and its consumer.
interface prio_encoder_rr_if #(
  parameter int N = 8
);
  localparam int IDXW = $clog2(N);

  logic            en;
  logic [N-1:0]    req;
  logic            mode_wr;
  logic            mode_in;
  logic [IDXW-1:0] out_idx;
  logic [N-1:0]    out_onehot;
  logic            out_multi;
  logic            out_valid;
  logic            out_ready;
  logic            mode;

  modport master (
    output en, req, mode_wr, mode_in, out_ready,
    input  out_idx, out_onehot, out_multi, out_valid, mode
  );

  modport slave (
    input  en, req, mode_wr, mode_in, out_ready,
    output out_idx, out_onehot, out_multi, out_valid, mode
  );

endinterface

// File: rtl/prio_encoder_rr_find.sv
// Combinational winner search: rotate so the start index sits at the top,
// take the highest set bit, then map that index back to the original position.
module prio_find
  import prio_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  input  logic            mode,
  output logic [IDXW-1:0] win,
  output logic            found,
  output logic            multi
);

  logic [IDXW-1:0] top;
  logic [63:0]     req64;
  logic [63:0]     rot;
  int              amt;
  int              h;
  int              orig;

  always_comb begin
    // Fixed priority is the same search anchored permanently at N-1.
    top   = (mode == MODE_RR) ? start : IDXW'(N - 1);
    amt   = (N - 1) - int'(top);
    req64 = '0;
    req64[N-1:0] = req;
    rot   = rot_up(req64, amt, N);
    h     = int'(highest_set(rot));
    orig  = (h >= amt) ? h - amt : h + N - amt;
    win   = IDXW'(orig);
  end

  assign found = |req;
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin arbitration and a
// valid/ready result stage that holds under back-pressure.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter int   N          = 8,
  parameter int   IDXW       = $clog2(N),
  parameter logic RR_DEFAULT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  prio_encoder_rr_if.slave      bus
);

  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    onehot_q, onehot_d;
  logic            multi_q, multi_d;
  logic            valid_q, valid_d;
  logic            mode_q, mode_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic [IDXW-1:0] win;
  logic            found;
  logic            multi;
  logic            load;

  prio_find #(.N(N), .IDXW(IDXW)) u_find (
    .req   (bus.req),
    .start (ptr_q),
    .mode  (mode_q),
    .win   (win),
    .found (found),
    .multi (multi)
  );

  // A held result that is not being accepted blocks any new capture.
  assign load = bus.en && found && (!valid_q || bus.out_ready);

  always_comb begin
    idx_d    = idx_q;
    onehot_d = onehot_q;
    multi_d  = multi_q;
    valid_d  = valid_q;
    mode_d   = mode_q;
    ptr_d    = ptr_q;
    if (load) begin
      idx_d         = win;
      onehot_d      = '0;
      onehot_d[win] = 1'b1;
      multi_d       = multi;
      valid_d       = 1'b1;
      if (mode_q == MODE_RR) begin
        ptr_d = (win == '0) ? IDXW'(N - 1) : win - IDXW'(1);
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d  = 1'b0;
      onehot_d = '0;
    end
    if (bus.mode_wr) mode_d = bus.mode_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
      valid_q  <= 1'b0;
      mode_q   <= RR_DEFAULT;
      ptr_q    <= IDXW'(N - 1);
    end else begin
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
      valid_q  <= valid_d;
      mode_q   <= mode_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_multi  = multi_q;
  assign bus.out_valid  = valid_q;
  assign bus.mode       = mode_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr (N=8): fixed and round-robin arbitration,
// stall hold, drain, enable gating and asynchronous reset mid-handshake.
module tb_prio_encoder_rr;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  prio_encoder_rr_if #(.N(8)) bus ();

  prio_encoder_rr #(.N(8), .RR_DEFAULT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                         input logic [7:0] oh, input logic m);
    chk({tag, ".valid"},  64'(bus.out_valid),  64'(v));
    chk({tag, ".idx"},    64'(bus.out_idx),    64'(idx));
    chk({tag, ".onehot"}, 64'(bus.out_onehot), 64'(oh));
    chk({tag, ".multi"},  64'(bus.out_multi),  64'(m));
  endtask

  logic [2:0] rr_seq [9];

  initial begin
    total = 0;
    bad   = 0;
    rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.req = '0;
    bus.mode_wr = 1'b0;
    bus.mode_in = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("reset.mode", 64'(bus.mode), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // First capture: one-cycle latency
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    bus.req = 8'b0000_1001;
    step();
    chk_out("first", 1'b1, 3'd3, 8'h08, 1'b1);

    // Fixed mode keeps picking the top bit back to back
    bus.req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("fixed81", 1'b1, 3'd7, 8'h80, 1'b1);
    end
    bus.req = 8'h01;
    step();
    chk_out("fixed01", 1'b1, 3'd0, 8'h01, 1'b0);

    // Mode write cycle still loads with the old (fixed) mode; ptr stays 7
    bus.mode_wr = 1'b1;
    bus.mode_in = 1'b1;
    bus.req = 8'hFF;
    step();
    chk_out("modewr", 1'b1, 3'd7, 8'h80, 1'b1);
    chk("modewr.mode", 64'(bus.mode), 64'(1));
    bus.mode_wr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rrFF.idx", 64'(bus.out_idx), 64'(rr_seq[i]));
    end

    // ptr is now 6: 8'h24 picks 5, ptr -> 4; then stall while req changes
    bus.req = 8'h24;
    step();
    chk_out("rr24", 1'b1, 3'd5, 8'h20, 1'b1);
    bus.out_ready = 1'b0;
    bus.req = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 1'b1, 3'd5, 8'h20, 1'b1);
    end
    bus.out_ready = 1'b1;
    step();
    chk_out("unstall", 1'b1, 3'd0, 8'h01, 1'b0);

    // ptr is 7: 8'h04 picks 2, ptr -> 1; then drain with req=0
    bus.req = 8'h04;
    step();
    chk_out("rr04", 1'b1, 3'd2, 8'h04, 1'b0);
    bus.req = 8'h00;
    step();
    chk_out("drain", 1'b0, 3'd2, 8'h00, 1'b0);

    // en=0 blocks capture
    bus.en = 1'b0;
    bus.req = 8'hFF;
    step();
    chk_out("en0", 1'b0, 3'd2, 8'h00, 1'b0);
    bus.en = 1'b1;

    // ptr is 1: search 1,0,7,6,5,4 -> 4
    bus.req = 8'h10;
    step();
    chk_out("rr10", 1'b1, 3'd4, 8'h10, 1'b0);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk_out("async", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("async.mode", 64'(bus.mode), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Back to RR with ptr restored to 7: 8'hFF yields 7 then 6
    bus.mode_wr = 1'b1;
    bus.mode_in = 1'b1;
    bus.req = 8'h00;
    step();
    chk("post.valid", 64'(bus.out_valid), 64'(0));
    bus.mode_wr = 1'b0;
    bus.req = 8'hFF;
    step();
    chk_out("post1", 1'b1, 3'd7, 8'h80, 1'b1);
    step();
    chk_out("post2", 1'b1, 3'd6, 8'h40, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
